// File: rtl/entropy_pkg.sv
// Shared defaults and counter-width helpers for the entropy health packer.
package entropy_pkg;

  localparam int unsigned RCT_CUTOFF_DEF = 8;
  localparam int unsigned APT_WINDOW_DEF = 64;
  localparam int unsigned APT_CUTOFF_DEF = 48;
  localparam int unsigned OUT_W_DEF      = 8;

  // Width of a counter that must hold values 0..max_val inclusive.
  function automatic int unsigned cnt_w(int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned RCT_CNT_W_DEF  = cnt_w(RCT_CUTOFF_DEF);
  localparam int unsigned APT_WCNT_W_DEF = $clog2(APT_WINDOW_DEF);
  localparam int unsigned APT_MCNT_W_DEF = cnt_w(APT_CUTOFF_DEF);
  localparam int unsigned BCNT_W_DEF     = $clog2(OUT_W_DEF);

endpackage

// File: rtl/entropy_health_tests.sv
// Repetition count and adaptive proportion tests on a strobed raw bit stream.
module entropy_health_tests
  import entropy_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF = RCT_CUTOFF_DEF,
  parameter int unsigned APT_WINDOW = APT_WINDOW_DEF,
  parameter int unsigned APT_CUTOFF = APT_CUTOFF_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_i,
  input  logic bit_i,
  input  logic clear_i,
  output logic rct_fail_o,
  output logic apt_fail_o,
  output logic fail_set_o
);

  localparam int unsigned RctW = cnt_w(RCT_CUTOFF);
  localparam int unsigned WinW = $clog2(APT_WINDOW);
  localparam int unsigned AptW = cnt_w(APT_CUTOFF);
  localparam logic [RctW-1:0] RctMax = RctW'(RCT_CUTOFF);
  localparam logic [AptW-1:0] AptMax = AptW'(APT_CUTOFF);

  logic [RctW-1:0] run_cnt_q, run_cnt_d;
  logic            last_bit_q, last_bit_d;
  logic [WinW-1:0] wcnt_q, wcnt_d;
  logic            ref_bit_q, ref_bit_d;
  logic [AptW-1:0] match_q, match_d;
  logic            rct_fail_q, rct_fail_d;
  logic            apt_fail_q, apt_fail_d;
  logic            rct_hit, apt_hit;

  always_comb begin
    run_cnt_d  = run_cnt_q;
    last_bit_d = last_bit_q;
    wcnt_d     = wcnt_q;
    ref_bit_d  = ref_bit_q;
    match_d    = match_q;
    rct_hit    = 1'b0;
    apt_hit    = 1'b0;
    if (clear_i) begin
      run_cnt_d  = '0;
      last_bit_d = 1'b0;
      wcnt_d     = '0;
      ref_bit_d  = 1'b0;
      match_d    = '0;
    end else if (sample_i) begin
      // run_cnt of zero marks "no history" after reset or clear
      if (run_cnt_q == '0 || bit_i != last_bit_q) begin
        run_cnt_d = RctW'(1);
      end else if (run_cnt_q != RctMax) begin
        run_cnt_d = run_cnt_q + 1'b1;
      end
      last_bit_d = bit_i;
      rct_hit    = (run_cnt_d == RctMax);

      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == '0) begin
        ref_bit_d = bit_i;
        match_d   = AptW'(1);
      end else if (bit_i == ref_bit_q && match_q != AptMax) begin
        match_d = match_q + 1'b1;
      end
      apt_hit = (match_d == AptMax);
    end
    rct_fail_d = !clear_i && (rct_fail_q || rct_hit);
    apt_fail_d = !clear_i && (apt_fail_q || apt_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q  <= '0;
      last_bit_q <= 1'b0;
      wcnt_q     <= '0;
      ref_bit_q  <= 1'b0;
      match_q    <= '0;
      rct_fail_q <= 1'b0;
      apt_fail_q <= 1'b0;
    end else begin
      run_cnt_q  <= run_cnt_d;
      last_bit_q <= last_bit_d;
      wcnt_q     <= wcnt_d;
      ref_bit_q  <= ref_bit_d;
      match_q    <= match_d;
      rct_fail_q <= rct_fail_d;
      apt_fail_q <= apt_fail_d;
    end
  end

  assign rct_fail_o = rct_fail_q;
  assign apt_fail_o = apt_fail_q;
  assign fail_set_o = (rct_hit && !rct_fail_q) || (apt_hit && !apt_fail_q);

endmodule

// File: rtl/entropy_health_packer.sv
// Health-checks a raw entropy stream and packs passing bits MSB-first into words.
module entropy_health_packer
  import entropy_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF = RCT_CUTOFF_DEF,
  parameter int unsigned APT_WINDOW = APT_WINDOW_DEF,
  parameter int unsigned APT_CUTOFF = APT_CUTOFF_DEF,
  parameter int unsigned OUT_W      = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             entropy_valid,
  input  logic             entropy_bit,
  input  logic             clear_alarm,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready,
  output logic             rct_fail,
  output logic             apt_fail,
  output logic             alarm,
  output logic             overflow
);

  localparam int unsigned BcntW = $clog2(OUT_W);
  localparam logic [BcntW-1:0] BcntLast = BcntW'(OUT_W - 1);

  logic [OUT_W-1:0] sr_q, sr_d;
  logic [BcntW-1:0] bcnt_q, bcnt_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             overflow_q, overflow_d;
  logic             fail_set;
  logic             take, pop;
  logic [OUT_W-1:0] word;

  entropy_health_tests #(
    .RCT_CUTOFF (RCT_CUTOFF),
    .APT_WINDOW (APT_WINDOW),
    .APT_CUTOFF (APT_CUTOFF)
  ) u_tests (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_i   (entropy_valid),
    .bit_i      (entropy_bit),
    .clear_i    (clear_alarm),
    .rct_fail_o (rct_fail),
    .apt_fail_o (apt_fail),
    .fail_set_o (fail_set)
  );

  assign alarm = rct_fail | apt_fail;
  assign pop   = out_valid_q && out_ready;
  assign take  = entropy_valid && !clear_alarm && !alarm && !fail_set;
  assign word  = {sr_q[OUT_W-2:0], entropy_bit};

  always_comb begin
    sr_d        = sr_q;
    bcnt_d      = bcnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overflow_d  = 1'b0;
    if (clear_alarm || fail_set) begin
      // A word completing on the failing edge is discarded silently
      sr_d        = '0;
      bcnt_d      = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end else begin
      if (pop) begin
        out_valid_d = 1'b0;
      end
      if (take) begin
        sr_d   = word;
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == BcntLast) begin
          bcnt_d = '0;
          if (!out_valid_q || pop) begin
            out_valid_d = 1'b1;
            out_data_d  = word;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q        <= '0;
      bcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      bcnt_q      <= bcnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_entropy_health_packer.sv
// Directed and randomized checks of entropy_health_packer against a history-based model.
module tb_entropy_health_packer;

  localparam int RCT  = 8;
  localparam int WIN  = 64;
  localparam int APTC = 48;
  localparam int W    = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         entropy_valid, entropy_bit, clear_alarm, out_ready;
  logic         out_valid, rct_fail, apt_fail, alarm, overflow;
  logic [W-1:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: every sample since reset/clear, plus the bits of the partial word
  bit       hist[$];
  bit       pk[$];
  bit       m_rct, m_apt, m_valid, m_ovf;
  bit [W-1:0] m_data;

  always #5 clk = ~clk;

  entropy_health_packer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .entropy_valid (entropy_valid),
    .entropy_bit   (entropy_bit),
    .clear_alarm   (clear_alarm),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .rct_fail      (rct_fail),
    .apt_fail      (apt_fail),
    .alarm         (alarm),
    .overflow      (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_clear();
    hist.delete();
    pk.delete();
    m_rct   = 1'b0;
    m_apt   = 1'b0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_data  = '0;
  endtask

  task automatic model_edge(input bit v, input bit b, input bit clr, input bit rdy);
    bit pre_alarm, rct_hit, apt_hit, refb;
    int n, wstart, cnt;
    bit [W-1:0] w;
    pre_alarm = m_rct || m_apt;
    m_ovf = 1'b0;
    if (clr) begin
      model_clear();
    end else begin
      if (m_valid && rdy) m_valid = 1'b0;
      if (v) begin
        hist.push_back(b);
        n = hist.size();
        rct_hit = (n >= RCT);
        if (rct_hit)
          for (int k = 0; k < RCT; k++) if (hist[n-1-k] != b) rct_hit = 1'b0;
        wstart = ((n - 1) / WIN) * WIN;
        refb = hist[wstart];
        cnt = 0;
        for (int i = wstart; i < n; i++) if (hist[i] == refb) cnt++;
        apt_hit = (cnt >= APTC);
        m_rct = m_rct | rct_hit;
        m_apt = m_apt | apt_hit;
        if (!pre_alarm && (rct_hit || apt_hit)) begin
          pk.delete();
          m_valid = 1'b0;
        end else if (!pre_alarm) begin
          pk.push_back(b);
          if (pk.size() == W) begin
            w = '0;
            foreach (pk[i]) w = {w[W-2:0], pk[i]};
            pk.delete();
            if (!m_valid) begin
              m_valid = 1'b1;
              m_data  = w;
            end else begin
              m_ovf = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("rct_fail", 32'(rct_fail), 32'(m_rct));
    chk("apt_fail", 32'(apt_fail), 32'(m_apt));
    chk("alarm", 32'(alarm), 32'(m_rct | m_apt));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_valid) chk("out_data", 32'(out_data), 32'(m_data));
  endtask

  task automatic step(input bit v, input bit b, input bit clr, input bit rdy);
    entropy_valid = v;
    entropy_bit   = b;
    clear_alarm   = clr;
    out_ready     = rdy;
    model_edge(v, b, clr, rdy);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_rct", 32'(rct_fail), 0);
    chk("rst_apt", 32'(apt_fail), 0);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_overflow", 32'(overflow), 0);
    model_clear();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit [7:0] pat;
    int bias;
    rst_n = 1'b0;
    entropy_valid = 1'b0;
    entropy_bit = 1'b0;
    clear_alarm = 1'b0;
    out_ready = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // 1: alternating stream, consumer always ready
    for (int i = 0; i < 32; i++) begin
      step(1, i[0], 0, 1);
      if (i % 8 == 7) begin
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_data", 32'(out_data), 'h55);
      end
    end

    // 2: run of 7 passes, run of 8 fails, clear restarts packing
    step(0, 0, 1, 1);
    for (int i = 0; i < 7; i++) step(1, 1, 0, 1);
    step(1, 0, 0, 1);
    chk("t2_rct_7", 32'(rct_fail), 0);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 1);
    chk("t2_rct_8", 32'(rct_fail), 1);
    chk("t2_alarm", 32'(alarm), 1);
    chk("t2_gated", 32'(out_valid), 0);
    step(1, 1, 1, 1);
    chk("t2_cleared", 32'(alarm), 0);
    for (int i = 0; i < 8; i++) step(1, i[0], 0, 1);
    chk("t2_resume_valid", 32'(out_valid), 1);
    chk("t2_resume_data", 32'(out_data), 'h55);

    // 3: 1,1,1,0 pattern trips the APT on sample index 62
    step(0, 0, 1, 1);
    for (int i = 0; i < 64; i++) begin
      step(1, (i % 4) != 3, 0, 1);
      if (i == 61) chk("t3_apt_61", 32'(apt_fail), 0);
      if (i == 62) chk("t3_apt_62", 32'(apt_fail), 1);
    end
    chk("t3_rct", 32'(rct_fail), 0);

    // 4: stalled consumer, second word overflows
    step(0, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, i[0], 0, 0);
      if (i == 7) chk("t4_data_8", 32'(out_data), 'h55);
      if (i == 15) begin
        chk("t4_ovf", 32'(overflow), 1);
        chk("t4_data_16", 32'(out_data), 'h55);
      end
    end
    step(0, 0, 0, 0);
    chk("t4_ovf_pulse", 32'(overflow), 0);

    // 5: pop on the same edge a new word completes
    pat = 8'h33;
    for (int i = 0; i < 8; i++) step(1, pat[7-i], 0, (i == 7));
    chk("t5_valid", 32'(out_valid), 1);
    chk("t5_data", 32'(out_data), 'h33);
    chk("t5_ovf", 32'(overflow), 0);

    // 6: reset mid-word, then a fresh word
    step(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(1, i[0], 0, 1);
    do_reset();
    pat = 8'h96;
    for (int i = 0; i < 8; i++) step(1, pat[7-i], 0, 1);
    chk("t6_valid", 32'(out_valid), 1);
    chk("t6_data", 32'(out_data), 'h96);

    // Randomized traffic with a varying bit bias to exercise both tests
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) bias = (($urandom % 3) == 0) ? 78 : 50;
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step(($urandom % 4) != 0, ($urandom_range(0, 99) < bias), 
             (alarm && ($urandom % 8) == 0) || ($urandom_range(0, 299) == 0),
             ($urandom % 2) == 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
